// File: rtl/counter_scheduler.sv
// counter_scheduler
//
// Purpose:
//   Time-shares one Size-bit up-counter among Requesters clients. Clients
//   are served round-robin. The owner's duration is latched when the grant
//   is issued. The counter then runs from 0 up to that duration. When it
//   reaches the duration, a one-cycle done pulse goes to the owner.
//
// Optional feature macro: COUNTER_SCHEDULER_BACK2BACK_EN
//   When the macro is defined, the DONE state arbitrates by itself. The
//   finishing owner's request is masked for that one decision. If another
//   client is waiting, it is granted on the next edge with no IDLE cycle.
//   When the macro is undefined, DONE always returns to IDLE. This leaves
//   at least one all-zero grant cycle between jobs.
//
// Ports:
//   clock    : sole clock; all state updates on posedge
//   reset    : synchronous, active-low
//   req      : per-client request level; must stay high for the whole job
//   duration : packed per-client durations, client i at [i*Size +: Size]
//   grant    : one-hot owner indicator; zero when idle
//   done     : one-cycle completion pulse to the owner
//   count    : current counter value
//   owner    : index of the current or most recent owner
//   busy     : high while a job is running or completing

module counter_scheduler #(
  parameter int Size       = 5,
  parameter int Requesters = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [Requesters-1:0]         req,
  input  logic [Requesters*Size-1:0]    duration,
  output logic [Requesters-1:0]         grant,
  output logic [Requesters-1:0]         done,
  output logic [Size-1:0]               count,
  output logic [$clog2(Requesters)-1:0] owner,
  output logic                          busy
);

  localparam int IdxW = $clog2(Requesters);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [Size-1:0] count_q, count_d;
  logic [Size-1:0] dur_q, dur_d;

  logic [Size-1:0]       dur_arr [Requesters];
  logic [Requesters-1:0] owner_dec;
  logic [Requesters-1:0] arb_mask;
  logic                  arb_found;
  logic [IdxW-1:0]       arb_idx;
  logic [IdxW-1:0]       cand;

  // Unpack the duration bus and decode the owner index to one-hot.
  for (genvar gi = 0; gi < Requesters; gi++) begin : g_client
    assign dur_arr[gi]   = duration[gi*Size +: Size];
    assign owner_dec[gi] = (owner_q == IdxW'(gi));
  end

  // In DONE, the finishing owner must not win straight back. In IDLE, the
  // full request vector takes part in arbitration.
`ifdef COUNTER_SCHEDULER_BACK2BACK_EN
  assign arb_mask = (state_q == ST_DONE) ? (req & ~owner_dec) : req;
`else
  assign arb_mask = req;
`endif

  // Round-robin search. It starts one past the last winner and wraps
  // modulo Requesters, which also works for non-power-of-two client counts.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= Requesters; k++) begin
      cand = IdxW'((int'(ptr_q) + k) % Requesters);
      if (!arb_found && arb_mask[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Next-state logic for the FSM and the datapath.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    count_d = count_q;
    dur_d   = dur_q;

    unique case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (arb_found) begin
          state_d = ST_RUN;
          owner_d = arb_idx;
          ptr_d   = arb_idx;
          dur_d   = dur_arr[arb_idx];
        end
      end

      ST_RUN: begin
        if (!req[owner_q]) begin
          // The owner withdrew: abort without a done pulse. The pointer
          // stays on the aborted owner, so the search resumes after it.
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_q == dur_q) begin
          state_d = ST_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        count_d = '0;
`ifdef COUNTER_SCHEDULER_BACK2BACK_EN
        if (arb_found) begin
          state_d = ST_RUN;
          owner_d = arb_idx;
          ptr_d   = arb_idx;
          dur_d   = dur_arr[arb_idx];
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= IdxW'(Requesters - 1);
      owner_q <= '0;
      count_q <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      count_q <= count_d;
      dur_q   <= dur_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign grant = busy ? owner_dec : '0;
  assign done  = (state_q == ST_DONE) ? owner_dec : '0;
  assign count = count_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Testbench for counter_scheduler (Size=5, Requesters=4).
// The stimulus process pushes one expected record for each grant tenure.
// A separate monitor process tracks each tenure as it runs. It pops and
// compares the expected record when the tenure ends.

module tb_counter_scheduler;

  localparam int SZ = 5;
  localparam int NR = 4;

`ifdef COUNTER_SCHEDULER_BACK2BACK_EN
  localparam int JOB_GAP = 0;
`else
  localparam int JOB_GAP = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*SZ-1:0] duration;
  logic [NR-1:0]    grant;
  logic [NR-1:0]    done;
  logic [SZ-1:0]    count;
  logic [1:0]       owner;
  logic             busy;

  counter_scheduler #(.Size(SZ), .Requesters(NR)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .req      (req),
    .duration (duration),
    .grant    (grant),
    .done     (done),
    .count    (count),
    .owner    (owner),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NR-1:0] grant;
    int            len;
    logic [SZ-1:0] last_count;
    bit            done_seen;
    int            gap;        // -1: gap not checked
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [NR-1:0] g, input int len,
                          input logic [SZ-1:0] lc, input bit d, input int gap);
    exp_t e;
    e.grant      = g;
    e.len        = len;
    e.last_count = lc;
    e.done_seen  = d;
    e.gap        = gap;
    exp_q.push_back(e);
  endtask

  task automatic set_dur(input int i, input logic [SZ-1:0] v);
    duration[i*SZ +: SZ] = v;
  endtask

  // Bounded waits, all evaluated on the falling edge.
  task automatic wait_done(input string nm);
    int n = 0;
    while (done == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done == '0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_grant(input string nm, input logic [NR-1:0] g);
    int n = 0;
    while (grant !== g && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (grant !== g) chk({nm, "_timeout"}, 32'(grant), 32'(g));
  endtask

  task automatic wait_grant_count(input string nm, input logic [NR-1:0] g,
                                  input logic [SZ-1:0] c);
    int n = 0;
    while (!(grant === g && count === c) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(grant === g && count === c)) chk({nm, "_timeout"}, 32'(count), 32'(c));
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit            t_act    = 1'b0;
  logic [NR-1:0] t_grant  = '0;
  int            t_len    = 0;
  logic [SZ-1:0] t_last   = '0;
  bit            t_done   = 1'b0;
  int            t_gap    = 0;
  int            idle_cnt = 0;
  logic [SZ-1:0] prev_cnt = '0;
  int            tenure_n = 0;

  always @(negedge clk) begin
    chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    chk("busy_vs_grant", 32'(busy), 32'(grant != '0));
    chk("done_within_grant", 32'(done & ~grant), 32'd0);
    if (grant != '0) chk("owner_vs_grant", 32'(grant), 32'(4'b0001 << owner));

    if (t_act && grant !== t_grant) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_tenure", 32'(t_grant), 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("tenure %0d: grant=%b len=%0d last_count=%0d done=%0d gap=%0d",
                 tenure_n, t_grant, t_len, t_last, t_done, t_gap);
        chk("tenure_grant", 32'(t_grant), 32'(e.grant));
        chk("tenure_len", 32'(t_len), 32'(e.len));
        chk("tenure_last_count", 32'(t_last), 32'(e.last_count));
        chk("tenure_done", 32'(t_done), 32'(e.done_seen));
        if (e.gap >= 0) chk("tenure_gap", 32'(t_gap), 32'(e.gap));
      end
      tenure_n++;
      t_act    = 1'b0;
      idle_cnt = 0;
    end

    if (!t_act && grant != '0) begin
      t_act    = 1'b1;
      t_grant  = grant;
      t_len    = 0;
      t_done   = 1'b0;
      t_gap    = idle_cnt;
      idle_cnt = 0;
    end

    if (t_act) begin
      if (t_len == 0)      chk("count_start", 32'(count), 32'd0);
      else if (done != '0) chk("count_hold_done", 32'(count), 32'(prev_cnt));
      else                 chk("count_step", 32'(count), 32'(prev_cnt + 1'b1));
      if (done != '0) begin
        t_done = 1'b1;
        chk("done_owner", 32'(done), 32'(t_grant));
      end
      t_len++;
      t_last   = count;
      prev_cnt = count;
    end else begin
      idle_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    req      = '0;
    duration = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_grant", 32'(grant), 32'd0);
      chk("t1_count", 32'(count), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_owner", 32'(owner), 32'd0);
    end
    $display("t1: idle after reset checked for 10 cycles");

    // 2: single job, duration 3
    set_dur(0, 5'd3);
    req = 4'b0001;
    push_exp(4'b0001, 5, 5'd3, 1'b1, -1);
    @(negedge clk);
    chk("t2_grant_latency", 32'(grant), 32'b0001);
    wait_done("t2_done");
    req = '0;
    $display("t2: single job duration 3 issued");

    // 3: all requesting, durations 0, round-robin from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    duration = '0;
    req      = 4'b1111;
    push_exp(4'b0001, 2, 5'd0, 1'b1, -1);
    push_exp(4'b0010, 2, 5'd0, 1'b1, JOB_GAP);
    push_exp(4'b0100, 2, 5'd0, 1'b1, JOB_GAP);
    push_exp(4'b1000, 2, 5'd0, 1'b1, JOB_GAP);
    push_exp(4'b0001, 2, 5'd0, 1'b1, JOB_GAP);
    for (int j = 0; j < 5; j++) begin
      wait_done("t3_done");
      if (j < 4) @(negedge clk);
    end
    req = '0;
    $display("t3: round-robin sequence of 5 jobs issued");

    // 4: abort client 2 at count 10, then client 3 is served
    @(negedge clk);
    set_dur(2, 5'd31);
    set_dur(3, 5'd2);
    req = 4'b1101;
    push_exp(4'b0100, 11, 5'd10, 1'b0, -1);
    push_exp(4'b1000, 4, 5'd2, 1'b1, 1);
    wait_grant_count("t4_count10", 4'b0100, 5'd10);
    req = 4'b1001;
    @(negedge clk);
    chk("t4_abort_grant", 32'(grant), 32'd0);
    chk("t4_abort_count", 32'(count), 32'd0);
    chk("t4_abort_done", 32'(done), 32'd0);
    wait_grant("t4_next", 4'b1000);
    req = 4'b1000;
    wait_done("t4_done");
    req = '0;
    $display("t4: abort of client 2 and follow-on client 3 issued");

    // 5: duration change after grant is ignored
    @(negedge clk);
    set_dur(1, 5'd5);
    req = 4'b0010;
    push_exp(4'b0010, 7, 5'd5, 1'b1, -1);
    wait_grant("t5_grant", 4'b0010);
    set_dur(1, 5'd1);
    wait_done("t5_done");
    chk("t5_done_count", 32'(count), 32'd5);
    req = '0;
    $display("t5: latched duration job issued");

    // 6: reset mid-job, then client 0 wins first
    @(negedge clk);
    set_dur(2, 5'd20);
    req = 4'b0100;
    push_exp(4'b0100, 8, 5'd7, 1'b0, -1);
    wait_grant_count("t6_count7", 4'b0100, 5'd7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_owner", 32'(owner), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    duration = '0;
    req      = 4'b1111;
    push_exp(4'b0001, 2, 5'd0, 1'b1, -1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant("t6_first", 4'b0001);
    req = 4'b0001;
    wait_done("t6_done");
    req = '0;
    $display("t6: reset mid-job and post-reset grant issued");

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
